// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types -- types shared across the RV32I core and its memory hierarchy.
//
// Contents:
//   rv32i_word   : 32-bit architectural word
//   rv32i_reg    : 5-bit register index
//   arb_state_t  : state encoding of the L1 I/D -> L2 arbiter (l1_l2_arbiter)
// -----------------------------------------------------------------------------
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  // Explicit encodings keep the state values stable in waveforms and in any
  // legacy code that compares against raw bit patterns.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

endpackage : rv32i_types

// File: rtl/l1_l2_arbiter.sv
// -----------------------------------------------------------------------------
// l1_l2_arbiter -- shares one L2 port between the L1 I-cache and L1 D-cache.
//
// A requester is granted on a clock edge (registered grant); while it owns the
// port its request is forwarded combinationally to the L2 and the L2 response
// is routed back combinationally. The owner is never preempted; ownership
// returns to IDLE on the edge that sees l2_resp (or as soon as the owner drops
// its request), so a new grant always follows at least one IDLE cycle.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : contention goes to the requester that was
//                                   not granted last (1-bit last-owner reg).
//                       undefined : D-cache wins every contention.
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   i_read, i_address              I-cache line read request
//   i_rdata, i_resp                I-cache read data / completion pulse
//   d_read, d_write, d_address,    D-cache line request
//   d_wdata
//   d_rdata, d_resp                D-cache read data / completion pulse
//   l2_read, l2_write, l2_address, request to the shared L2
//   l2_wdata
//   l2_rdata, l2_resp              L2 read data / completion
// -----------------------------------------------------------------------------
module l1_l2_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t state_q;
  arb_state_t state_d;
  arb_state_t contention_grant;
  logic       d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D-cache received the most recent grant. Reset value 0 makes the first
  // contention go to D.
  logic last_d_q;
`endif

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case leaves them unassigned and no latch is inferred.
    state_d    = state_q;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    // Read data is a straight wire; only the resp pulses qualify it.
    i_rdata    = l2_rdata;
    d_rdata    = l2_rdata;

    d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    contention_grant = last_d_q ? SERVE_I : SERVE_D;
`else
    contention_grant = SERVE_D;
`endif

    case (state_q)
      IDLE: begin
        if (d_req && i_read) state_d = contention_grant;
        else if (d_req)      state_d = SERVE_D;
        else if (i_read)     state_d = SERVE_I;
      end

      SERVE_I: begin
        // A dropped request abandons the transaction silently: nothing is
        // forwarded and any L2 response in this cycle is not reported.
        if (!i_read) begin
          state_d = IDLE;
        end else begin
          l2_read    = 1'b1;
          l2_address = i_address;
          i_resp     = l2_resp;
          if (l2_resp) state_d = IDLE;
        end
      end

      SERVE_D: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          // Read and write together forward the write only.
          l2_write   = d_write;
          l2_read    = d_read & ~d_write;
          l2_address = d_address;
          l2_wdata   = d_wdata;
          d_resp     = l2_resp;
          if (l2_resp) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      // A grant is exactly an IDLE -> SERVE_x transition.
      if (state_q == IDLE && state_d != IDLE) last_d_q <= (state_d == SERVE_D);
`endif
    end
  end

endmodule : l1_l2_arbiter

// File: tb/tb_l1_l2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l1_l2_arbiter -- directed, table-driven bench for l1_l2_arbiter.
//
// Each table row gives the inputs for one clock cycle and the combinational
// outputs expected in that cycle (before the next rising edge). Inputs change
// on the falling edge; outputs are sampled 1 ns later. The rows are grouped
// into the multi-cycle scenarios: single I read with 5-cycle L2 latency, D
// write with an I request arriving mid-service, read+write collapse, reset
// mid-transaction, dropped request, and contention under either arbitration
// build (ARB_ROUND_ROBIN_EN selects the expected grant order).
// -----------------------------------------------------------------------------
module tb_l1_l2_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] I_ADDR  = 32'h0000_0040;
  localparam logic [ADDR_W-1:0] D_ADDR  = 32'h0000_1000;
  localparam logic [LINE_W-1:0] WDATA   = {32{8'h5A}};
  localparam logic [LINE_W-1:0] RDATA   = {32{8'hAB}};
  localparam logic [LINE_W-1:0] NODATA  = {32{8'hC3}};

  // Expected owner of the L2 port in a row.
  localparam int N  = 0;
  localparam int SI = 1;
  localparam int SD = 2;

  typedef struct {
    bit rst;
    bit ir;
    bit dr;
    bit dw;
    bit resp;
    bit e_rd;
    bit e_wr;
    int sel;
    bit e_iresp;
    bit e_dresp;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  l1_l2_arbiter #(
    .LINE_W(LINE_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_address (i_address),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_address(l2_address),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_resp   (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int row,
                       input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit ir, bit dr, bit dw, bit resp,
                              bit e_rd, bit e_wr, int sel, bit e_ir, bit e_dr);
    vec_t v;
    v.rst = r;  v.ir = ir;  v.dr = dr;  v.dw = dw;  v.resp = resp;
    v.e_rd = e_rd;  v.e_wr = e_wr;  v.sel = sel;
    v.e_iresp = e_ir;  v.e_dresp = e_dr;
    return v;
  endfunction

  initial begin
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata;
    logic [LINE_W-1:0] drv_rdata;

    // ---- reset, stray response in IDLE ---------------------------------
    vecs.push_back(mk(0,0,0,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(0,1,1,1,1, 0,0,N ,0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,N ,0,0));
    // ---- I read, L2 answers after 5 request cycles ---------------------
    vecs.push_back(mk(1,1,0,0,0, 0,0,N ,0,0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1,1,0,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(1,1,0,0,1, 1,0,SI,1,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,N ,0,0));
    // ---- D write; I request arrives during SERVE_D and waits -----------
    vecs.push_back(mk(1,0,0,1,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,0,0,1,0, 0,1,SD,0,0));
    vecs.push_back(mk(1,1,0,1,0, 0,1,SD,0,0));
    vecs.push_back(mk(1,1,0,1,1, 0,1,SD,0,1));
    vecs.push_back(mk(1,1,0,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(1,1,0,0,1, 1,0,SI,1,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,N ,0,0));
    // ---- d_read and d_write together: write only -----------------------
    vecs.push_back(mk(1,0,1,1,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,0,1,1,0, 0,1,SD,0,0));
    vecs.push_back(mk(1,0,1,1,1, 0,1,SD,0,1));
    vecs.push_back(mk(1,0,0,0,0, 0,0,N ,0,0));
    // ---- reset during SERVE_I, late L2 resp ignored --------------------
    vecs.push_back(mk(1,1,0,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,0,0,1, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(1,1,0,0,1, 1,0,SI,1,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,N ,0,0));
    // ---- owner drops request before resp; then a D read (last owner D) -
    vecs.push_back(mk(1,1,0,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,N ,0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,N ,0,0));
    vecs.push_back(mk(1,0,1,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,0,1,0,0, 1,0,SD,0,0));
    vecs.push_back(mk(1,0,1,0,1, 1,0,SD,0,1));
    vecs.push_back(mk(1,0,0,0,0, 0,0,N ,0,0));
    // ---- contention after reset: D first in both builds ----------------
    vecs.push_back(mk(0,1,1,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,1,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,1,0,0, 1,0,SD,0,0));
    vecs.push_back(mk(1,1,1,0,1, 1,0,SD,0,1));
    vecs.push_back(mk(1,1,1,0,0, 0,0,N ,0,0));
`ifdef ARB_ROUND_ROBIN_EN
    // Back-to-back contention: I was not served last, so I goes next.
    vecs.push_back(mk(1,1,1,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(1,1,1,0,1, 1,0,SI,1,0));
    vecs.push_back(mk(1,0,1,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,0,1,0,0, 1,0,SD,0,0));
    vecs.push_back(mk(1,0,1,0,1, 1,0,SD,0,1));
    vecs.push_back(mk(1,0,0,0,0, 0,0,N ,0,0));
`else
    // Fixed priority: D wins again; I follows once D stops requesting.
    vecs.push_back(mk(1,1,1,0,0, 1,0,SD,0,0));
    vecs.push_back(mk(1,1,1,0,1, 1,0,SD,0,1));
    vecs.push_back(mk(1,1,0,0,0, 0,0,N ,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,SI,0,0));
    vecs.push_back(mk(1,1,0,0,1, 1,0,SI,1,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,N ,0,0));
`endif

    rst       = 1'b0;
    i_read    = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    l2_resp   = 1'b0;
    i_address = I_ADDR;
    d_address = D_ADDR;
    d_wdata   = WDATA;
    l2_rdata  = NODATA;

    foreach (vecs[r]) begin
      @(negedge clk);
      rst       = vecs[r].rst;
      i_read    = vecs[r].ir;
      d_read    = vecs[r].dr;
      d_write   = vecs[r].dw;
      l2_resp   = vecs[r].resp;
      drv_rdata = vecs[r].resp ? RDATA : NODATA;
      l2_rdata  = drv_rdata;
      #1;

      case (vecs[r].sel)
        SI:      begin exp_addr = I_ADDR; exp_wdata = '0;    end
        SD:      begin exp_addr = D_ADDR; exp_wdata = WDATA; end
        default: begin exp_addr = '0;     exp_wdata = '0;    end
      endcase

      check("l2_read",    r, LINE_W'(l2_read),    LINE_W'(vecs[r].e_rd));
      check("l2_write",   r, LINE_W'(l2_write),   LINE_W'(vecs[r].e_wr));
      check("l2_address", r, LINE_W'(l2_address), LINE_W'(exp_addr));
      check("l2_wdata",   r, l2_wdata,            exp_wdata);
      check("i_resp",     r, LINE_W'(i_resp),     LINE_W'(vecs[r].e_iresp));
      check("d_resp",     r, LINE_W'(d_resp),     LINE_W'(vecs[r].e_dresp));
      check("i_rdata",    r, i_rdata,             drv_rdata);
      check("d_rdata",    r, d_rdata,             drv_rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_l1_l2_arbiter

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256: cacheline width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_read  input  1 / i_address  input  ADDR_W: I-cache line-read request.
REQ-006 SHALL have ports i_rdata  output  LINE_W / i_resp  output  1: I-cache read data and completion pulse.
REQ-007 SHALL have ports d_read  input  1 / d_write  input  1 / d_address  input  ADDR_W / d_wdata  input  LINE_W: D-cache line request.
REQ-008 SHALL have ports d_rdata  output  LINE_W / d_resp  output  1: D-cache read data and completion pulse.
REQ-009 SHALL have ports l2_read  output  1 / l2_write  output  1 / l2_address  output  ADDR_W / l2_wdata  output  LINE_W: request to the shared L2.
REQ-010 SHALL have ports l2_rdata  input  LINE_W / l2_resp  input  1: L2 read data and completion.

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; exactly one requester is owned outside IDLE.
REQ-012 In IDLE, SHALL issue nothing to L2: l2_read, l2_write and both resp outputs are 0.
REQ-013 IDLE -> SERVE_I if only i_read is set; IDLE -> SERVE_D if only d_read or d_write is set.
REQ-014 With both requesters active in IDLE, SHALL choose per the arbitration policy (REQ-024/025).
REQ-015 In SERVE_x, SHALL drive l2_read/l2_write/l2_address/l2_wdata combinationally from the owner's inputs (l2_write and l2_wdata are 0 in SERVE_I).
REQ-016 In SERVE_x, SHALL drive x_resp = l2_resp and x_rdata = l2_rdata combinationally; the non-owner's resp is 0.
REQ-017 SHALL drive i_rdata and d_rdata to l2_rdata at all times; only resp qualifies them.
REQ-018 On posedge with l2_resp=1 in SERVE_x, SHALL return to IDLE; there is no direct SERVE_I <-> SERVE_D transition.
REQ-019 Latency: grant is registered, so the L2 request starts 1 cycle after request assertion. Owner completes in L2 latency + 1. The next request is granted no earlier than 1 cycle after a resp.
REQ-020 Requesters SHALL hold request, address and wdata stable until resp. The arbiter SHALL NOT preempt the owner.
REQ-021 If the owner drops its request before l2_resp (protocol violation), SHALL return to IDLE on the next edge with no resp.
REQ-022 If d_read and d_write are both 1, SHALL forward the write only (l2_read=0).
REQ-023 An I-cache request arriving while SERVE_D is active SHALL wait; no request SHALL be lost or duplicated.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined, SHALL keep a 1-bit last-owner register updated on each grant. On contention, SHALL grant the requester not served last.
REQ-025 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority: D-cache wins every contention, and no last-owner register is built.

Reset
REQ-026 On rst=0, SHALL asynchronously enter IDLE. The last-owner register SHALL favour D (next contention goes to D).
REQ-027 During reset, l2_read, l2_write, i_resp and d_resp SHALL be 0. l2_address and l2_wdata SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no resp. Any L2 resp arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-029 The state enum arb_state_t (IDLE, SERVE_I, SERVE_D) SHALL live in shared package rv32i_types, alongside existing types.
REQ-030 SHALL have no sub-module. The FSM, next-state logic and output muxing are one always_ff and one always_comb.

Verification
REQ-031 Scenario: i_read=1, addr 0x0000_0040, L2 resp after 5 cycles with rdata 0xAB..AB -> i_resp high 1 cycle at cycle 6, i_rdata=0xAB..AB, d_resp=0.
REQ-032 Scenario: d_write=1, addr 0x0000_1000, wdata 0x5A..5A -> l2_write=1, l2_address=0x1000, l2_wdata=0x5A..5A; d_resp on l2_resp; return to IDLE.
REQ-033 Scenario: i_read and d_read asserted same cycle after reset, RR build -> D served first, then I. Fixed build -> D first. Back-to-back repeat under RR -> I served first.
REQ-034 Scenario: i_read arrives during SERVE_D -> no L2 glitch; I granted the cycle after d_resp; exactly one i_resp.
REQ-035 Scenario: rst pulled low during SERVE_I, 2 cycles before l2_resp -> outputs 0 immediately, FSM IDLE, no i_resp after release.
REQ-036 Scenario: d_read and d_write both 1 -> only l2_write asserted.
